// File: rtl/axis_log_pkg.sv
// Shared definitions for the log packager: serializer phases, header field
// offsets derived from the stream widths, and the header fit check.
package axis_log_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      HDR   = 2'd1,
      DATA  = 2'd2
   } phase_e;

   // Header fields are packed LSB first: seq, id, dest, keep, last.
   function automatic int seq_lsb();
      return 0;
   endfunction

   function automatic int id_lsb(input int seq_w);
      return seq_lsb() + seq_w;
   endfunction

   function automatic int dest_lsb(input int seq_w, input int id_w);
      return id_lsb(seq_w) + id_w;
   endfunction

   function automatic int keep_lsb(input int seq_w, input int id_w, input int dest_w);
      return dest_lsb(seq_w, id_w) + dest_w;
   endfunction

   function automatic int last_bit(input int seq_w, input int id_w, input int dest_w,
                                   input int data_w);
      return keep_lsb(seq_w, id_w, dest_w) + data_w / 8;
   endfunction

   function automatic bit header_fits(input int seq_w, input int id_w, input int dest_w,
                                      input int data_w);
      return (data_w % 8 == 0) && (last_bit(seq_w, id_w, dest_w, data_w) < data_w);
   endfunction

endpackage

// File: rtl/axis_log_hold.sv
// One-entry holding slice with a registered ready: the upstream ready is a
// flop, so there is no combinational path from in_valid to in_ready.
module axis_log_hold #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_take
);

   logic accept;
   logic full_next;

   always_comb begin
      accept    = in_valid & in_ready;
      // A take and an accept on the same edge leave the slot full with the new flit.
      full_next = accept | (out_valid & ~out_take);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         in_ready  <= 1'b0;
      end else begin
         out_valid <= full_next;
         in_ready  <= ~full_next;
      end
   end

   // NOTE: the payload register has no reset; it is only observed while out_valid
   // is set, and leaving it unreset keeps the datapath free of reset fan-out.
   always_ff @(posedge clk) begin
      if (accept) out_data <= in_data;
   end

endmodule

// File: rtl/axis_log_packager.sv
// Accepts governor log flits through a registered-ready slice and re-emits each
// one as a two-beat packet: a header beat (side channels + sequence) then data.
module axis_log_packager
   import axis_log_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int DEST_WIDTH = 16,
   parameter int ID_WIDTH   = 16,
   parameter int SEQ_WIDTH  = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [DATA_WIDTH-1:0]   log_TDATA,
   input  logic                    log_TVALID,
   output logic                    log_TREADY,
   input  logic [DATA_WIDTH/8-1:0] log_TKEEP,
   input  logic [DEST_WIDTH-1:0]   log_TDEST,
   input  logic [ID_WIDTH-1:0]     log_TID,
   input  logic                    log_TLAST,
   output logic [DATA_WIDTH-1:0]   pkt_TDATA,
   output logic                    pkt_TVALID,
   input  logic                    pkt_TREADY,
   output logic [DATA_WIDTH/8-1:0] pkt_TKEEP,
   output logic                    pkt_TLAST,
   input  logic                    seq_clr
);

   localparam int KEEP_W   = DATA_WIDTH / 8;
   localparam int SEQ_LSB  = seq_lsb();
   localparam int ID_LSB   = id_lsb(SEQ_WIDTH);
   localparam int DEST_LSB = dest_lsb(SEQ_WIDTH, ID_WIDTH);
   localparam int KEEP_LSB = keep_lsb(SEQ_WIDTH, ID_WIDTH, DEST_WIDTH);
   localparam int LAST_BIT = last_bit(SEQ_WIDTH, ID_WIDTH, DEST_WIDTH, DATA_WIDTH);
   localparam int PW       = LAST_BIT + 1 + DATA_WIDTH;

   if (!header_fits(SEQ_WIDTH, ID_WIDTH, DEST_WIDTH, DATA_WIDTH)) begin : g_bad_widths
      $error("axis_log_packager: header fields do not fit in DATA_WIDTH");
   end

   logic                 accept;
   logic [SEQ_WIDTH-1:0] cnt;
   logic [SEQ_WIDTH-1:0] stamp;
   logic [PW-1:0]        in_payload;
   logic [PW-1:0]        h_payload;
   logic                 h_full;
   logic                 take;
   logic                 s_free;
   logic [PW-1:0]        s_payload;
   phase_e               phase;
   phase_e               phase_next;
   logic [DATA_WIDTH-1:0] hdr;

   assign accept = log_TVALID & log_TREADY;
   assign stamp  = seq_clr ? '0 : cnt;

   // Payload is laid out in header order so the header is its low bits verbatim.
   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      in_payload                          = '0;
      in_payload[SEQ_LSB +: SEQ_WIDTH]    = stamp;
      in_payload[ID_LSB +: ID_WIDTH]      = log_TID;
      in_payload[DEST_LSB +: DEST_WIDTH]  = log_TDEST;
      in_payload[KEEP_LSB +: KEEP_W]      = log_TKEEP;
      in_payload[LAST_BIT]                = log_TLAST;
      in_payload[PW-1 -: DATA_WIDTH]      = log_TDATA;
   end

   axis_log_hold #(.WIDTH(PW)) u_hold (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_data  (in_payload),
      .in_valid (log_TVALID),
      .in_ready (log_TREADY),
      .out_data (h_payload),
      .out_valid(h_full),
      .out_take (take)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) cnt <= '0;
      else        cnt <= stamp + SEQ_WIDTH'(accept);
   end

   always_comb begin
      s_free     = (phase == EMPTY) || (phase == DATA && pkt_TREADY);
      take       = s_free && h_full;
      phase_next = phase;
      if (s_free)                          phase_next = h_full ? HDR : EMPTY;
      else if (phase == HDR && pkt_TREADY) phase_next = DATA;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) phase <= EMPTY;
      else        phase <= phase_next;
   end

   always_ff @(posedge clk) begin
      if (take) s_payload <= h_payload;
   end

   always_comb begin
      hdr               = '0;
      hdr[LAST_BIT:0]   = s_payload[LAST_BIT:0];
      pkt_TVALID        = (phase != EMPTY);
      pkt_TDATA         = '0;
      pkt_TKEEP         = '0;
      pkt_TLAST         = 1'b0;
      case (phase)
         HDR: begin
            pkt_TDATA = hdr;
            pkt_TKEEP = '1;
         end
         DATA: begin
            pkt_TDATA = s_payload[PW-1 -: DATA_WIDTH];
            pkt_TKEEP = s_payload[KEEP_LSB +: KEEP_W];
            pkt_TLAST = 1'b1;
         end
         default: ;
      endcase
   end

endmodule
